// File: rtl/kconv_pkg.sv
// Shared types and constants for the kernel convolver: FSM state encoding,
// pixel type, accumulator width and the output saturation helper.
package kconv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_DIV,
    ST_OUT
  } kconv_state_e;

  typedef logic [7:0] pixel_t;

  localparam int unsigned ACC_W     = 32;
  localparam int unsigned DIV_STEPS = 32;

  function automatic pixel_t sat_pixel(input logic [ACC_W-1:0] q);
    return (q > ACC_W'(255)) ? 8'hFF : q[7:0];
  endfunction

endpackage

// File: rtl/kconv_divider.sv
// Unsigned restoring divider: operands captured on start, one quotient bit per
// cycle for DIV_STEPS cycles, done pulses for one cycle with quotient valid.
module kconv_divider
  import kconv_pkg::*;
(
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic [ACC_W-1:0] dividend,
  input  logic [ACC_W-1:0] divisor,
  output logic             done,
  output logic [ACC_W-1:0] quotient
);

  localparam int unsigned CNT_W = $clog2(DIV_STEPS);

  logic [ACC_W-1:0] rem_q, quo_q, dvs_q;
  logic [ACC_W-1:0] rem_d, quo_d;
  logic [ACC_W:0]   shifted;
  logic [CNT_W-1:0] step_cnt_q;
  logic             active_q, done_q;

  // quo_q doubles as the dividend shift register; quotient bits enter at the LSB
  always_comb begin
    shifted = {rem_q, quo_q[ACC_W-1]};
    rem_d   = shifted[ACC_W-1:0];
    quo_d   = {quo_q[ACC_W-2:0], 1'b0};
    if (shifted >= {1'b0, dvs_q}) begin
      rem_d    = ACC_W'(shifted - {1'b0, dvs_q});
      quo_d[0] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      step_cnt_q <= '0;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        rem_q      <= '0;
        quo_q      <= dividend;
        dvs_q      <= divisor;
        step_cnt_q <= '0;
        active_q   <= 1'b1;
      end else if (active_q) begin
        rem_q      <= rem_d;
        quo_q      <= quo_d;
        step_cnt_q <= step_cnt_q + CNT_W'(1);
        if (step_cnt_q == CNT_W'(DIV_STEPS - 1)) begin
          active_q <= 1'b0;
          done_q   <= 1'b1;
        end
      end
    end
  end

  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/kernel_convolver.sv
// Sequential N x N kernel convolver with normalizing divide and saturation.
// Optional KCONV_ROUND_EN: round-to-nearest by adding sum/2 before dividing.
module kernel_convolver
  import kconv_pkg::*;
#(
  parameter int MAX_KERNAL = 7
) (
  input  logic                                     clk,
  input  logic                                     n_rst,
  input  logic                                     kernel_load,
  input  logic [$clog2(MAX_KERNAL)-1:0]            kernel_size,
  input  logic [MAX_KERNAL-1:0][MAX_KERNAL-1:0][7:0] kernel,
  input  logic [ACC_W-1:0]                         sum,
  input  logic                                     win_valid,
  output logic                                     win_ready,
  input  logic [MAX_KERNAL-1:0][MAX_KERNAL-1:0][7:0] window,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [7:0]                               out_pixel,
  output logic                                     busy,
  output logic                                     err_zero_sum
);

  localparam int unsigned KSW = $clog2(MAX_KERNAL);
  localparam int unsigned NW  = $clog2(MAX_KERNAL + 1);

  typedef logic [MAX_KERNAL-1:0][MAX_KERNAL-1:0][7:0] kmat_t;

  kconv_state_e state_q, state_d;

  kmat_t            sh_kernel_q, k_q, win_q;
  logic [ACC_W-1:0] sh_sum_q, sum_q, acc_q;
  logic [KSW-1:0]   sh_size_q;
  logic [NW-1:0]    n_q, x_q, y_q, n_last;
  logic [5:0]       div_cnt_q;
  pixel_t           out_pixel_q;
  logic             err_q;

  logic [15:0]      prod;
  logic [ACC_W-1:0] acc_next, dividend, div_quot;
  logic             accept, mac_last, sum_zero, out_fire, div_start, div_done;

  function automatic logic [NW-1:0] clamp_n(input logic [KSW-1:0] s);
    logic [31:0] sw;
    sw = 32'(s);
    if (sw == '0) return NW'(1);
    if (sw > 32'(MAX_KERNAL)) return NW'(MAX_KERNAL);
    return NW'(s);
  endfunction

  assign accept   = win_valid && win_ready;
  assign prod     = k_q[x_q][y_q] * win_q[x_q][y_q];
  assign acc_next = acc_q + ACC_W'(prod);
  assign n_last   = n_q - NW'(1);
  assign mac_last = (x_q == n_last) && (y_q == n_last);
  assign sum_zero = (sum_q == '0);
  assign out_fire = (state_q == ST_DIV) && (state_d == ST_OUT);

  // The final product is folded in combinationally so division starts on the last MAC edge
`ifdef KCONV_ROUND_EN
  assign dividend = acc_next + (sum_q >> 1);
`else
  assign dividend = acc_next;
`endif

  assign div_start = (state_q == ST_MAC) && mac_last && !sum_zero;

  kconv_divider u_div (
    .clk      (clk),
    .n_rst    (n_rst),
    .start    (div_start),
    .dividend (dividend),
    .divisor  (sum_q),
    .done     (div_done),
    .quotient (div_quot)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // A zero divisor never starts the divider; the DIV cycle count keeps timing identical
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (win_valid) state_d = ST_MAC;
      ST_MAC:  if (mac_last) state_d = ST_DIV;
      ST_DIV:  if (sum_zero ? (div_cnt_q == 6'(DIV_STEPS)) : div_done) state_d = ST_OUT;
      ST_OUT:  if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    win_ready = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    out_valid = (state_q == ST_OUT);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sh_kernel_q <= '0;
      sh_sum_q    <= '0;
      sh_size_q   <= '0;
      k_q         <= '0;
      sum_q       <= '0;
      n_q         <= '0;
      win_q       <= '0;
      acc_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      div_cnt_q   <= '0;
      out_pixel_q <= '0;
      err_q       <= 1'b0;
    end else begin
      if (kernel_load) begin
        sh_kernel_q <= kernel;
        sh_sum_q    <= sum;
        sh_size_q   <= kernel_size;
      end

      // A load coinciding with acceptance bypasses the shadow
      if (accept) begin
        k_q   <= kernel_load ? kernel : sh_kernel_q;
        sum_q <= kernel_load ? sum : sh_sum_q;
        n_q   <= clamp_n(kernel_load ? kernel_size : sh_size_q);
        win_q <= window;
        acc_q <= '0;
        x_q   <= '0;
        y_q   <= '0;
      end else if (state_q == ST_MAC) begin
        acc_q <= acc_next;
        if (x_q == n_last) begin
          x_q <= '0;
          y_q <= y_q + NW'(1);
        end else begin
          x_q <= x_q + NW'(1);
        end
      end

      div_cnt_q <= (state_q == ST_DIV) ? div_cnt_q + 6'd1 : '0;

      if (out_fire) out_pixel_q <= sum_zero ? 8'hFF : sat_pixel(div_quot);

      if (out_fire && sum_zero)             err_q <= 1'b1;
      else if (kernel_load && sum != '0)    err_q <= 1'b0;
    end
  end

  assign out_pixel    = out_pixel_q;
  assign err_zero_sum = err_q;

endmodule

// File: tb/tb_kernel_convolver.sv
// Self-checking bench for kernel_convolver: directed table, handshake and
// reset sequences, and randomized windows against a behavioural model.
module tb_kernel_convolver;

  localparam int MK = 7;
  typedef logic [MK-1:0][MK-1:0][7:0] kmat_t;

  typedef struct {
    string       name;
    kmat_t       k;
    kmat_t       w;
    logic [31:0] s;
    int          n;
    int          exp_pix;
    int          exp_lat;
    bit          exp_err;
  } vec_t;

  logic        clk, n_rst, kernel_load, win_valid, win_ready;
  logic        out_valid, out_ready, busy, err_zero_sum;
  logic [2:0]  kernel_size;
  kmat_t       kernel, window;
  logic [31:0] sum;
  logic [7:0]  out_pixel;

  int     n_cmp = 0;
  int     n_err = 0;
  longint cyc = 0;
  longint acc_cyc = 0;
  vec_t   tbl[7];

  kernel_convolver #(.MAX_KERNAL(MK)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .kernel_load  (kernel_load),
    .kernel_size  (kernel_size),
    .kernel       (kernel),
    .sum          (sum),
    .win_valid    (win_valid),
    .win_ready    (win_ready),
    .window       (window),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pixel    (out_pixel),
    .busy         (busy),
    .err_zero_sum (err_zero_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic kmat_t fill(input int v);
    kmat_t m;
    for (int x = 0; x < MK; x++)
      for (int y = 0; y < MK; y++) m[x][y] = 8'(v);
    return m;
  endfunction

  function automatic kmat_t rnd_mat();
    kmat_t m;
    for (int x = 0; x < MK; x++)
      for (int y = 0; y < MK; y++) m[x][y] = 8'($urandom);
    return m;
  endfunction

  function automatic int n_eff(input int n);
    return (n == 0) ? 1 : ((n > MK) ? MK : n);
  endfunction

  function automatic longint coef_sum(input kmat_t k, input int n);
    longint t = 0;
    for (int x = 0; x < n_eff(n); x++)
      for (int y = 0; y < n_eff(n); y++) t += longint'(k[x][y]);
    return t;
  endfunction

  // Weighted sum over the active N x N corner, normalized and saturated
  function automatic int model(input kmat_t k, input kmat_t w, input longint s, input int n);
    longint a = 0;
    for (int x = 0; x < n_eff(n); x++)
      for (int y = 0; y < n_eff(n); y++) a += longint'(k[x][y]) * longint'(w[x][y]);
    if (s == 0) return 255;
`ifdef KCONV_ROUND_EN
    a += s / 2;
`endif
    a = a / s;
    return (a > 255) ? 255 : int'(a);
  endfunction

  task automatic load_kernel(input kmat_t k, input logic [31:0] s, input int n);
    kernel = k; sum = s; kernel_size = 3'(n); kernel_load = 1'b1;
    @(posedge clk); @(negedge clk);
    kernel_load = 1'b0; kernel = rnd_mat(); sum = $urandom; kernel_size = 3'($urandom);
  endtask

  task automatic accept_window(input string name, input kmat_t w, input bit with_load);
    check({name, "_ready"}, win_ready, 1);
    window = w; win_valid = 1'b1; kernel_load = with_load;
    @(posedge clk); @(negedge clk);
    win_valid = 1'b0; kernel_load = 1'b0; window = rnd_mat();
    kernel = rnd_mat(); sum = $urandom;
    acc_cyc = cyc;
  endtask

  task automatic finish_window(input string name, input int exp_lat, input int exp_pix,
                               input bit exp_err, input int hold);
    while (!out_valid && (cyc - acc_cyc) < 400) @(negedge clk);
    check({name, "_lat"}, cyc - acc_cyc, exp_lat);
    check({name, "_pix"}, out_pixel, exp_pix);
    check({name, "_err"}, err_zero_sum, exp_err);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      check({name, "_hold_valid"}, out_valid, 1);
      check({name, "_hold_pix"}, out_pixel, exp_pix);
      check({name, "_hold_ready"}, win_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    check({name, "_idle_ready"}, win_ready, 1);
    check({name, "_idle_valid"}, out_valid, 0);
  endtask

  initial begin
    int    ov_seen;
    int    n, e, sel;
    kmat_t k, w;
    logic [31:0] s;

    tbl[0] = '{"ones",   fill(1),   fill(100), 32'd9,   3, 100, 42, 1'b0};
    tbl[1] = '{"center", fill(0),   fill(200), 32'd100, 3, 37,  42, 1'b0};
    tbl[1].k[1][1] = 8'd100;
    tbl[1].w[1][1] = 8'd37;
    tbl[2] = '{"zero",   fill(1),   fill(100), 32'd0,   3, 255, 42, 1'b1};
    tbl[3] = '{"sat",    fill(255), fill(255), 32'd1,   2, 255, 37, 1'b0};
    tbl[4] = '{"n0",     fill(1),   fill(50),  32'd4,   0, 125, 34, 1'b0};
    tbl[4].k[0][0] = 8'd10;
    tbl[5] = '{"n7",     fill(2),   fill(3),   32'd49,  7, 6,   82, 1'b0};
`ifdef KCONV_ROUND_EN
    tbl[6] = '{"round",  fill(1),   fill(10),  32'd4,   1, 3,   34, 1'b0};
`else
    tbl[6] = '{"round",  fill(1),   fill(10),  32'd4,   1, 2,   34, 1'b0};
`endif

    n_rst = 1'b0; kernel_load = 1'b0; win_valid = 1'b0; out_ready = 1'b0;
    kernel = '0; window = '0; sum = '0; kernel_size = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_pix", out_pixel, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_zero_sum, 0);
    check("rst_ready", win_ready, 1);
    n_rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      load_kernel(tbl[i].k, tbl[i].s, tbl[i].n);
      accept_window(tbl[i].name, tbl[i].w, 1'b0);
      check({tbl[i].name, "_busy"}, busy, 1);
      finish_window(tbl[i].name, tbl[i].exp_lat, tbl[i].exp_pix, tbl[i].exp_err, 0);
    end

    load_kernel(fill(4), 32'd0, 3);
    accept_window("zs", fill(20), 1'b0);
    finish_window("zs", 42, 255, 1'b1, 0);
    load_kernel(fill(1), 32'd9, 3);
    check("zs_clear", err_zero_sum, 0);

    w = fill(0);
    for (int x = 0; x < 3; x++)
      for (int y = 0; y < 3; y++) w[x][y] = 8'(x * 40 + y * 11 + 5);
    accept_window("stall", w, 1'b0);
    finish_window("stall", 42, model(fill(1), w, 9, 3), 1'b0, 10);

    load_kernel(fill(1), 32'd9, 3);
    accept_window("midmac_a", fill(100), 1'b0);
    @(negedge clk);
    load_kernel(fill(2), 32'd9, 3);
    finish_window("midmac_a", 42, 100, 1'b0, 0);
    accept_window("midmac_b", fill(100), 1'b0);
    finish_window("midmac_b", 42, 200, 1'b0, 0);
    kernel = fill(1); sum = 32'd18; kernel_size = 3'd3;
    accept_window("coincide", fill(100), 1'b1);
    finish_window("coincide", 42, 50, 1'b0, 0);

    for (int i = 0; i < 25; i++) begin
      n = $urandom_range(0, 7);
      k = rnd_mat();
      w = rnd_mat();
      sel = $urandom_range(0, 3);
      case (sel)
        0:       s = 32'd0;
        1:       s = 32'(coef_sum(k, n));
        2:       s = 32'($urandom_range(1, 1000));
        default: s = $urandom;
      endcase
      e = model(k, w, s, n);
      load_kernel(k, s, n);
      accept_window("rand", w, 1'b0);
      finish_window("rand", n_eff(n) * n_eff(n) + 33, e, s == 0, $urandom_range(0, 3));
    end

    load_kernel(fill(3), 32'd50, 3);
    accept_window("rstdiv", fill(7), 1'b0);
    while ((cyc - acc_cyc) < 20) @(negedge clk);
    check("rstdiv_busy", busy, 1);
    n_rst = 1'b0;
    #1;
    check("rstdiv_valid", out_valid, 0);
    check("rstdiv_pix", out_pixel, 0);
    check("rstdiv_busy0", busy, 0);
    check("rstdiv_err", err_zero_sum, 0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rstdiv_ready", win_ready, 1);
    ov_seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (out_valid) ov_seen++;
    end
    check("rstdiv_no_out", ov_seen, 0);

    // After reset the working set is empty: N clamps to 1 and the sum is zero
    accept_window("postrst", fill(9), 1'b0);
    finish_window("postrst", 34, 255, 1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/kernel_convolver.md
KERNEL_CONVOLVER -- requirements
Module: kernel_convolver

Interface
REQ-001 SHALL have parameter: MAX_KERNAL, default 7, largest supported kernel side.
REQ-002 SHALL have port: clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port: n_rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: kernel_load  input  1  one-cycle strobe; capture kernel, sum and kernel_size.
REQ-005 SHALL have port: kernel_size  input  $clog2(MAX_KERNAL)  active kernel side N.
REQ-006 SHALL have port: kernel  input  MAX_KERNAL x MAX_KERNAL x 8  coefficients, indexed [x][y].
REQ-007 SHALL have port: sum  input  32  sum of active coefficients (normalizer).
REQ-008 SHALL have port: win_valid  input  1  pixel window offered.
REQ-009 SHALL have port: win_ready  output  1  window accepted when win_valid && win_ready.
REQ-010 SHALL have port: window  input  MAX_KERNAL x MAX_KERNAL x 8  pixel window, indexed [x][y].
REQ-011 SHALL have port: out_valid  output  1  out_pixel valid.
REQ-012 SHALL have port: out_ready  input  1  downstream accepts out_pixel.
REQ-013 SHALL have port: out_pixel  output  8  normalized convolution result.
REQ-014 SHALL have port: busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port: err_zero_sum  output  1  sticky; set on a convolution with zero latched sum.

Function
REQ-016 SHALL implement FSM IDLE -> MAC -> DIV -> OUT -> IDLE; win_ready = (state == IDLE).
REQ-017 SHALL, on acceptance, register the window and clear the 32-bit accumulator.
REQ-018 SHALL, in MAC, add one product kernel[x][y]*window[x][y] per cycle, y outer, x inner, x,y in 0..N-1, for exactly N*N cycles.
REQ-019 SHALL clamp N: 0 treated as 1, values above MAX_KERNAL treated as MAX_KERNAL.
REQ-020 SHALL, in DIV, compute accumulator / latched sum by a 32-cycle restoring division.
REQ-021 SHALL saturate the quotient to 8'hFF when it exceeds 255.
REQ-022 SHALL, with latched sum == 0, skip division, output 8'hFF and set err_zero_sum.
REQ-023 SHALL assert out_valid exactly N*N+33 cycles after the acceptance edge (N*N MAC, 32 DIV, 1 register).
REQ-024 SHALL hold out_pixel and out_valid stable while out_valid && !out_ready; return to IDLE on the handshake cycle.
REQ-025 SHALL capture kernel_load into shadow registers in any state; the shadow is copied to the working set only at window acceptance, so a convolution in flight is never affected.
REQ-026 SHALL, when kernel_load and window acceptance coincide, use the newly loaded kernel for that window.
REQ-027 SHALL clear err_zero_sum only on reset or on kernel_load with a nonzero sum.

Reset
REQ-028 SHALL, on n_rst low, immediately enter IDLE; out_valid=0, out_pixel=0, busy=0, err_zero_sum=0, and shadow and working kernels, sum, N and accumulator all zero.
REQ-029 SHALL abort any in-flight convolution on reset with no output produced; win_ready=1 on the first cycle after release.

Configuration
REQ-030 SHALL, with KCONV_ROUND_EN defined, add (sum>>1) to the accumulator before division (round-to-nearest); without it, truncate.

Structure
REQ-031 SHALL place the FSM state enum, the pixel typedef (8-bit) and the accumulator width constant in package kconv_pkg.
REQ-032 SHALL implement the divider as sub-module kconv_divider (start/done, 32-bit dividend/divisor, 32-cycle latency).

Verification
REQ-033 SHALL test: N=3, all coefficients 1, sum=9, window all 100 -> out_pixel=100, out_valid at cycle 42 after acceptance.
REQ-034 SHALL test: N=3, center coefficient 100, others 0, sum=100, center pixel 37 -> out_pixel=37.
REQ-035 SHALL test: sum=0 -> out_pixel=8'hFF, err_zero_sum=1; next kernel_load with sum=9 clears it.
REQ-036 SHALL test: out_ready low for 10 cycles after out_valid -> out_pixel stable, win_ready=0 throughout.
REQ-037 SHALL test: kernel_load of a new kernel during MAC -> current result uses the old kernel; the next window uses the new kernel.
REQ-038 SHALL test: n_rst pulsed mid-DIV -> out_valid never asserts, all outputs zero, win_ready=1 after release.
